sha_msg_padder_p: RTL and testbench
===================================

SHA_MSG_PADDER_P -- requirements
Module: sha_msg_padder_p

Interface
REQ-001 SHALL have parameter DATA_W, default 64, stream word width in bits; legal values 32 or 64 only.
REQ-002 SHALL have parameter CNT_W, default 64, message bit-length counter width in bits; fixed at 64 by the SHA-1/SHA-256 padding rule.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, DATA_W, message word, big-endian, byte 0 = MSBs.
REQ-006 SHALL have port in_valid, input, 1, in_data valid.
REQ-007 SHALL have port in_last, input, 1, final word of message.
REQ-008 SHALL have port in_bytes, input, $clog2(DATA_W/8)+1, valid bytes in final word (0..DATA_W/8), ignored when in_last=0.
REQ-009 SHALL have port in_ready, output, 1, word accepted when in_valid & in_ready.
REQ-010 SHALL have port out_data, output, DATA_W, padded stream word.
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accept.
REQ-013 SHALL have port out_block_end, output, 1, word is word WPB-1 of a 512-bit block (WPB = 512/DATA_W).
REQ-014 SHALL have port out_last_block, output, 1, word belongs to the message's final block.
REQ-015 SHALL have port out_msg_end, output, 1, final word of padded message (out_block_end & out_last_block).

Function
REQ-016 SHALL register all outputs; an accepted input word SHALL appear on out_data exactly 1 cycle after acceptance when out_ready was high.
REQ-017 SHALL hold out_data and all flags stable while out_valid=1 and out_ready=0.
REQ-018 SHALL drive in_ready = (state==DATA) & (!out_valid | out_ready).
REQ-019 SHALL implement states DATA, PAD80, ZERO, LEN; DATA->LEN, DATA->ZERO or DATA->PAD80 on accepted in_last; PAD80->ZERO or LEN; ZERO->LEN at word WPB-LW; LEN->DATA after final length word, where LW = 64/DATA_W.
REQ-020 SHALL keep word index w (0..WPB-1) advancing on every output handshake, wrapping WPB-1->0.
REQ-021 SHALL pass non-last words unchanged and add DATA_W to the length counter per word.
REQ-022 SHALL, on last word with k<DATA_W/8 bytes, output bytes 0..k-1 of in_data, byte k = 0x80, remaining bytes 0, and add 8*k to the length; in_bytes=0 (empty word, empty message) SHALL yield 0x80 then zeros.
REQ-023 SHALL, on last word with k=DATA_W/8, output it unchanged and enter PAD80, emitting word 0x80 followed by zeros.
REQ-024 SHALL, when the 0x80 word index w <= WPB-1-LW, fill zeros to w=WPB-LW-1, then emit the length; otherwise SHALL fill zeros to w=WPB-1 and emit a second block of zeros ending in the length.
REQ-025 SHALL emit the 64-bit bit-length big-endian in the last LW words of the final block (DATA_W=32: high word then low word).
REQ-026 SHALL wrap the length counter modulo 2^64 without error.
REQ-027 SHALL assert out_last_block on every word of the final block only, computed once padding start position is known.
REQ-028 SHALL clear length counter and w to 0 after out_msg_end handshake, ready for next message with no idle cycle required.

Reset
REQ-029 SHALL on rst force out_valid, out_block_end, out_last_block, out_msg_end, out_data to 0, state DATA, w and length to 0; in_ready SHALL be 0 during rst.
REQ-030 SHALL abort any in-progress message on rst; the first message after release SHALL start at length 0, w=0.

Verification
REQ-031 DATA_W=32, "abc": in_data=0x61626300, in_last=1, in_bytes=3 -> 16 words: 0x61626380, 14x 0x00000000, 0x00000018; out_msg_end on word 15 only.
REQ-032 DATA_W=64, empty message: in_bytes=0, in_last=1 -> 0x8000000000000000, 6x zero, 0x0000000000000000; single block, out_last_block on all 8 words.
REQ-033 DATA_W=64, 55 bytes (last in_bytes=7) -> word6 byte7=0x80, word7=0x00000000000001B8; one block.
REQ-034 DATA_W=64, 56 bytes (7 full words, last in_bytes=8) -> block1 word7=0x8000000000000000, out_last_block=0 in block1; block2 7x zero then 0x00000000000001C0.
REQ-035 out_ready low 3 cycles mid-stream -> out_data/flags unchanged, in_ready=0, no word lost or duplicated.
REQ-036 rst asserted in ZERO state -> next cycle out_valid=0; following "abc" message yields exactly REQ-031 output.

Source files
------------

// File: rtl/sha_msg_padder_p.sv
// SHA-1/SHA-256 message padder: streams message words through, appends the 0x80 marker,
// zero fill and the 64-bit big-endian bit length, and flags block and message boundaries.
module sha_msg_padder_p #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [$clog2(DATA_W/8):0] in_bytes,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_block_end,
  output logic                      out_last_block,
  output logic                      out_msg_end
);
  localparam int BPW  = DATA_W / 8;
  localparam int KW   = $clog2(BPW) + 1;
  localparam int WPB  = 512 / DATA_W;
  localparam int LW   = 64 / DATA_W;
  localparam int WI_W = $clog2(WPB);
  localparam logic [WI_W-1:0]   W_END   = WI_W'(WPB - 1);
  localparam logic [WI_W-1:0]   W_PRE   = WI_W'(WPB - LW - 1);  // last word before the length field
  localparam logic [KW-1:0]     K_FULL  = KW'(BPW);
  localparam logic [DATA_W-1:0] WORD_80 = {8'h80, {(DATA_W-8){1'b0}}};

  typedef enum logic [1:0] {DATA = 2'd0, PAD80 = 2'd1, ZERO = 2'd2, LEN = 2'd3} state_t;

  state_t            state_r, state_nxt_s;
  logic [WI_W-1:0]   w_r;
  logic [CNT_W-1:0]  len_r, len_nxt_s;
  logic              last_blk_r, lb_nxt_s;
  logic [DATA_W-1:0] out_data_r, word_s, len_word_s;
  logic              out_valid_r, out_block_end_r, out_last_block_r, out_msg_end_r;
  logic              can_load_s, load_s, lastb_s;
  logic              pad_fit_s, pad_lb_s, full_lb_s;
  state_t            pad_state_s;

  // Keep bytes 0..k-1, put the 0x80 marker in byte k, zero the rest.
  function automatic logic [DATA_W-1:0] pad_word(input logic [DATA_W-1:0] d, input logic [KW-1:0] k);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < BPW; b++) begin
      if (b < int'(k))       r[DATA_W-1-8*b -: 8] = d[DATA_W-1-8*b -: 8];
      else if (b == int'(k)) r[DATA_W-1-8*b -: 8] = 8'h80;
      else                   r[DATA_W-1-8*b -: 8] = 8'h00;
    end
    return r;
  endfunction

  assign can_load_s     = !out_valid_r || out_ready;
  assign in_ready       = !rst && (state_r == DATA) && can_load_s;
  assign out_data       = out_data_r;
  assign out_valid      = out_valid_r;
  assign out_block_end  = out_block_end_r;
  assign out_last_block = out_last_block_r;
  assign out_msg_end    = out_msg_end_r;
  // High length word first when the length spans two words.
  assign len_word_s = DATA_W'(len_r >> ((w_r == W_END) ? 0 : (CNT_W - DATA_W)));

  // Next-state, next output word and the final-block decision once the marker position is known.
  always_comb begin
    load_s      = 1'b0;
    state_nxt_s = state_r;
    word_s      = '0;
    lastb_s     = 1'b0;
    lb_nxt_s    = last_blk_r;
    len_nxt_s   = len_r;
    pad_fit_s   = (w_r <= W_PRE);
    full_lb_s   = (w_r < W_PRE);
    if (w_r == W_END) begin
      pad_state_s = ZERO;
      pad_lb_s    = 1'b1;
    end else if (w_r == W_PRE) begin
      pad_state_s = LEN;
      pad_lb_s    = 1'b1;
    end else begin
      pad_state_s = ZERO;
      pad_lb_s    = pad_fit_s;
    end
    case (state_r)
      DATA: begin
        if (in_valid && can_load_s) begin
          load_s = 1'b1;
          if (!in_last) begin
            word_s    = in_data;
            len_nxt_s = len_r + CNT_W'(DATA_W);
          end else if (in_bytes >= K_FULL) begin
            word_s      = in_data;
            len_nxt_s   = len_r + CNT_W'(DATA_W);
            lastb_s     = full_lb_s;
            state_nxt_s = PAD80;
          end else begin
            word_s      = pad_word(in_data, in_bytes);
            len_nxt_s   = len_r + (CNT_W'(in_bytes) << 3);
            lastb_s     = pad_fit_s;
            state_nxt_s = pad_state_s;
            lb_nxt_s    = pad_lb_s;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      PAD80: begin
        if (can_load_s) begin
          load_s      = 1'b1;
          word_s      = WORD_80;
          lastb_s     = pad_fit_s;
          state_nxt_s = pad_state_s;
          lb_nxt_s    = pad_lb_s;
        end else begin
          load_s = 1'b0;
        end
      end
      ZERO: begin
        if (can_load_s) begin
          load_s  = 1'b1;
          lastb_s = last_blk_r;
          if (last_blk_r && (w_r == W_PRE)) begin
            state_nxt_s = LEN;
          end else if (!last_blk_r && (w_r == W_END)) begin
            lb_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ZERO;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      LEN: begin
        if (can_load_s) begin
          load_s  = 1'b1;
          word_s  = len_word_s;
          lastb_s = 1'b1;
          if (w_r == W_END) begin
            state_nxt_s = DATA;
            len_nxt_s   = '0;
            lb_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = LEN;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = DATA;
      end
    endcase
  end

  // State, counters and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= DATA;
      w_r              <= '0;
      len_r            <= '0;
      last_blk_r       <= 1'b0;
      out_data_r       <= '0;
      out_valid_r      <= 1'b0;
      out_block_end_r  <= 1'b0;
      out_last_block_r <= 1'b0;
      out_msg_end_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      len_r      <= len_nxt_s;
      last_blk_r <= lb_nxt_s;
      if (load_s) begin
        out_data_r       <= word_s;
        out_valid_r      <= 1'b1;
        out_block_end_r  <= (w_r == W_END);
        out_last_block_r <= lastb_s;
        out_msg_end_r    <= (state_r == LEN) && (w_r == W_END);
        w_r              <= w_r + WI_W'(1);
      end else if (can_load_s) begin
        out_valid_r      <= 1'b0;
        out_block_end_r  <= 1'b0;
        out_last_block_r <= 1'b0;
        out_msg_end_r    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sha_msg_padder_p.sv
// Bench for sha_msg_padder_p: one 32-bit and one 64-bit instance, a byte-level padding
// model feeding per-instance scoreboards, and a negedge monitor comparing output words.
module tb_sha_msg_padder_p;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data32, out_data32;
  logic [2:0]  in_bytes32;
  logic        in_valid32, in_last32, in_ready32, out_valid32, out_ready32, be32, lb32, me32;
  logic [63:0] in_data64, out_data64;
  logic [3:0]  in_bytes64;
  logic        in_valid64, in_last64, in_ready64, out_valid64, out_ready64, be64, lb64, me64;

  sha_msg_padder_p #(.DATA_W(32), .CNT_W(64)) u_dut32 (
    .clk(clk), .rst(rst), .in_data(in_data32), .in_valid(in_valid32), .in_last(in_last32),
    .in_bytes(in_bytes32), .in_ready(in_ready32), .out_data(out_data32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_block_end(be32), .out_last_block(lb32), .out_msg_end(me32));

  sha_msg_padder_p #(.DATA_W(64), .CNT_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_data(in_data64), .in_valid(in_valid64), .in_last(in_last64),
    .in_bytes(in_bytes64), .in_ready(in_ready64), .out_data(out_data64), .out_valid(out_valid64),
    .out_ready(out_ready64), .out_block_end(be64), .out_last_block(lb64), .out_msg_end(me64));

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          rdy_mode = 0;
  int          cyc = 0;
  logic [66:0] exp32_q[$];   // {msg_end, last_block, block_end, data[63:0]}
  logic [66:0] exp64_q[$];
  logic [7:0]  msg_q[$];
  logic        stall_p[2];
  logic [66:0] held_p[2];

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input int sel, input logic [66:0] v);
    if (sel == 0) exp32_q.push_back(v);
    else exp64_q.push_back(v);
  endtask

  // Pad at byte level (0x80, zeros to 56 mod 64, 8-byte length), then cut into words.
  task automatic model_push(input int sel, input int last_idx);
    logic [7:0]  p[$];
    logic [63:0] bitlen, word;
    int bpw, wpb, nw, nblk;
    p = msg_q;
    bitlen = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    bpw  = (sel == 0) ? 4 : 8;
    wpb  = 64 / bpw;
    nw   = p.size() / bpw;
    nblk = p.size() / 64;
    for (int i = 0; i < nw; i++) begin
      word = 64'd0;
      for (int b = 0; b < bpw; b++) word = {word[55:0], p[i*bpw+b]};
      push_exp(sel, {(i == nw - 1), ((i / wpb == nblk - 1) && (i >= last_idx)), (i % wpb == wpb - 1), word});
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [63:0] d, input logic last, input int k);
    if (sel == 0) begin
      in_valid32 = v; in_data32 = d[31:0]; in_last32 = last; in_bytes32 = 3'(k);
    end else begin
      in_valid64 = v; in_data64 = d; in_last64 = last; in_bytes64 = 4'(k);
    end
  endtask

  task automatic drive_word(input int sel, input logic [63:0] d, input logic last, input int k);
    int   t;
    logic hs;
    t  = 0;
    hs = 1'b0;
    @(negedge clk);
    #1 set_in(sel, 1'b1, d, last, k);
    while (!hs && t < 1000) begin
      #1 hs = (sel == 0) ? in_ready32 : in_ready64;
      @(posedge clk);
      if (!hs) begin
        @(negedge clk);
        #1 t++;
      end
    end
    if (!hs) begin
      chk("in_handshake_timeout", 67'd0, 67'd1);
    end else begin
      #1 chk("accept_latency_out_valid", {66'd0, ((sel == 0) ? out_valid32 : out_valid64)}, 67'd1);
    end
    set_in(sel, 1'b0, {$urandom, $urandom}, 1'b0, 0);
  endtask

  task automatic send_msg(input int sel, input bit tail_full);
    int n, bpw, nw, lastk, idx;
    logic [63:0] w;
    n   = msg_q.size();
    bpw = (sel == 0) ? 4 : 8;
    if (n == 0) begin nw = 1; lastk = 0; end
    else if (n % bpw != 0) begin nw = (n + bpw - 1) / bpw; lastk = n % bpw; end
    else if (tail_full) begin nw = n / bpw; lastk = bpw; end
    else begin nw = n / bpw + 1; lastk = 0; end
    model_push(sel, nw - 1);
    for (int j = 0; j < nw; j++) begin
      w = {$urandom, $urandom};   // bytes past the message stay random and must be masked
      for (int b = 0; b < bpw; b++) begin
        idx = j * bpw + b;
        if (idx < n) w[8*(bpw-1-b) +: 8] = msg_q[idx];
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      drive_word(sel, w, (j == nw - 1), (j == nw - 1) ? lastk : int'($urandom_range(0, bpw)));
    end
  endtask

  task automatic fill(input int n);
    msg_q.delete();
    repeat (n) msg_q.push_back(8'($urandom));
  endtask

  task automatic abc_expect();
    push_exp(0, {1'b0, 1'b1, 1'b0, 64'h0000_0000_6162_6380});
    for (int i = 1; i < 15; i++) push_exp(0, {1'b0, 1'b1, 1'b0, 64'd0});
    push_exp(0, {1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0018});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp32_q.size() != 0 || exp64_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 67'd0, 67'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic mon(input int sel, input logic ov, input logic ordy, input logic ir, input logic [66:0] act);
    logic [66:0] e;
    if (stall_p[sel]) begin
      chk("hold_out_valid", {66'd0, ov}, 67'd1);
      chk("hold_out_word", act, held_p[sel]);
    end
    if (ov && !ordy) begin
      chk("stall_in_ready", {66'd0, ir}, 67'd0);
      stall_p[sel] = 1'b1;
      held_p[sel]  = act;
    end else begin
      stall_p[sel] = 1'b0;
    end
    if (ov && ordy) begin
      if ((sel == 0 && exp32_q.size() == 0) || (sel == 1 && exp64_q.size() == 0)) begin
        n_chk++;
        $display("FAIL unexpected_word dut%0d: got %h expected none", sel, act);
      end else begin
        e = (sel == 0) ? exp32_q.pop_front() : exp64_q.pop_front();
        chk((sel == 0) ? "out_word32" : "out_word64", act, e);
      end
    end
  endtask

  // Output monitor: words and flags are stable from posedge+2 up to the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      stall_p[0] = 1'b0;
      stall_p[1] = 1'b0;
    end else begin
      mon(0, out_valid32, out_ready32, in_ready32, {me32, lb32, be32, 32'd0, out_data32});
      mon(1, out_valid64, out_ready64, in_ready64, {me64, lb64, be64, out_data64});
    end
  end

  // Downstream back-pressure: always ready, random, or a 3-cycle stall every 8 cycles.
  always @(posedge clk) begin
    #2 cyc++;
    case (rdy_mode)
      0: begin out_ready32 = 1'b1; out_ready64 = 1'b1; end
      1: begin
        out_ready32 = ($urandom_range(0, 3) != 0);
        out_ready64 = ($urandom_range(0, 3) != 0);
      end
      default: begin
        out_ready32 = !((cyc % 8) >= 3 && (cyc % 8) <= 5);
        out_ready64 = !((cyc % 8) >= 3 && (cyc % 8) <= 5);
      end
    endcase
  end

  initial begin
    rst = 1'b1;
    out_ready32 = 1'b1;
    out_ready64 = 1'b1;
    stall_p[0] = 1'b0;
    stall_p[1] = 1'b0;
    set_in(0, 1'b0, 64'd0, 1'b0, 0);
    set_in(1, 1'b0, 64'd0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready32", {66'd0, in_ready32}, 67'd0);
    chk("rst_in_ready64", {66'd0, in_ready64}, 67'd0);
    chk("rst_outputs32", {31'd0, me32, lb32, be32, out_valid32, out_data32}, 67'd0);
    chk("rst_outputs64", {me64, lb64, be64, out_valid64, out_data64[62:0]}, 67'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready64", {66'd0, in_ready64}, 67'd1);

    // "abc" on the 32-bit instance
    abc_expect();
    drive_word(0, 64'h6162_6300, 1'b1, 3);
    drain();
    // empty message, 55 bytes, 56 bytes on the 64-bit instance
    msg_q.delete();
    send_msg(1, 1'b0);
    drain();
    fill(55);
    send_msg(1, 1'b1);
    drain();
    fill(56);
    send_msg(1, 1'b1);
    drain();
    // periodic 3-cycle back-pressure mid-stream
    rdy_mode = 2;
    fill(100);
    send_msg(1, 1'b0);
    fill(37);
    send_msg(0, 1'b0);
    drain();
    // random messages and back-pressure
    rdy_mode = 1;
    repeat (30) begin
      fill($urandom_range(0, 140));
      send_msg($urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
    drain();
    // reset while zero-filling, then a clean "abc"
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    abc_expect();
    drive_word(0, 64'h6162_6300, 1'b1, 3);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    exp32_q.delete();
    #1 chk("mid_rst_out_valid32", {66'd0, out_valid32}, 67'd0);
    chk("mid_rst_in_ready32", {66'd0, in_ready32}, 67'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("after_rst_out_valid32", {66'd0, out_valid32}, 67'd0);
    abc_expect();
    drive_word(0, 64'h6162_6300, 1'b1, 3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
